conv_window_gen: RTL

Window fetcher that drives the 3x3 convolution MAC stage. For each pixel of a `matrix` x `matrix` feature map held in a synchronous-read RAM, it reads the nine kernel-window pixels and presents them as `w1..w9`. It also presents the matching column code `prov` and centre index `i`, then pulses `conv_en` for one cycle. Out-of-image neighbours are not read and are driven as zero.

---
 rtl/conv_window_gen.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen
// Fetches the 3x3 neighbourhood of every pixel in a matrix x matrix image
// held in a synchronous-read RAM and presents it to the convolution MAC.
// Each window takes 11 cycles: 9 FETCH slots, one WAIT for the last read
// to return, and one EMIT cycle with conv_en high.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           one-cycle request, honoured only while idle
//   matrix          image side length (2..31), latched on start
//   matrix2         matrix*matrix, latched on start
//   base_addr       RAM address of pixel 0 (row-major), latched on start
//   rd_en, rd_addr  RAM read strobe and address
//   rd_data         RAM data, valid the cycle after rd_en
//   w1..w9          window: centre, right, left, down-left, up-right,
//                   down, up, down-right, up-left (out-of-image = 0)
//   prov            column code: 11 = first column, 10 = last, 00 = other
//   i               centre pixel index
//   conv_en         one-cycle window-valid strobe
//   busy            high from the cycle after start through DONE
//   done            one-cycle pulse after the last window
module conv_window_gen #(
  parameter int SIZE = 23,
  parameter int ADDR = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4:0]             matrix,
  input  logic [9:0]             matrix2,
  input  logic [ADDR-1:0]        base_addr,
  output logic                   rd_en,
  output logic [ADDR-1:0]        rd_addr,
  input  logic [SIZE-1:0]        rd_data,
  output logic signed [SIZE-1:0] w1,
  output logic signed [SIZE-1:0] w2,
  output logic signed [SIZE-1:0] w3,
  output logic signed [SIZE-1:0] w4,
  output logic signed [SIZE-1:0] w5,
  output logic signed [SIZE-1:0] w6,
  output logic signed [SIZE-1:0] w7,
  output logic signed [SIZE-1:0] w8,
  output logic signed [SIZE-1:0] w9,
  output logic [1:0]             prov,
  output logic [9:0]             i,
  output logic                   conv_en,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]      k;
  logic [4:0]      row, col;
  logic [4:0]      matrix_l;
  logic [9:0]      matrix2_l;
  logic [ADDR-1:0] base_l;

  // Read issued in FETCH slot k is captured into w(k+1) one cycle later.
  logic            cap_en;
  logic [3:0]      cap_k;
  logic            cap_valid;
  logic [SIZE-1:0] win [9];

  logic [4:0]      last_idx;
  logic            has_left, has_right, has_up, has_down;
  logic [ADDR-1:0] m_ext, centre, slot_addr;
  logic            slot_valid;
  logic            advance;

  assign last_idx  = matrix_l - 5'd1;
  assign has_left  = (col != 5'd0);
  assign has_right = (col != last_idx);
  assign has_up    = (row != 5'd0);
  assign has_down  = (row != last_idx);
  assign m_ext     = ADDR'(matrix_l);
  assign centre    = base_l + ADDR'(i);
  assign advance   = (state == S_EMIT) && (i < matrix2_l - 10'd1);

  // Neighbour selection for the current slot; slot order fixes which w
  // register the returning data lands in.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot_valid = 1'b0;
    slot_addr  = centre;
    case (k)
      4'd0: begin slot_valid = 1'b1;                 slot_addr = centre;                       end
      4'd1: begin slot_valid = has_right;            slot_addr = centre + ADDR'(1);            end
      4'd2: begin slot_valid = has_left;             slot_addr = centre - ADDR'(1);            end
      4'd3: begin slot_valid = has_down && has_left; slot_addr = centre + m_ext - ADDR'(1);    end
      4'd4: begin slot_valid = has_up && has_right;  slot_addr = centre - m_ext + ADDR'(1);    end
      4'd5: begin slot_valid = has_down;             slot_addr = centre + m_ext;               end
      4'd6: begin slot_valid = has_up;               slot_addr = centre - m_ext;               end
      4'd7: begin slot_valid = has_down && has_right; slot_addr = centre + m_ext + ADDR'(1);   end
      4'd8: begin slot_valid = has_up && has_left;   slot_addr = centre - m_ext - ADDR'(1);    end
      default: begin slot_valid = 1'b0;              slot_addr = centre;                       end
    endcase
  end

  // Next state and decoded outputs.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    conv_en    = 1'b0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: begin
        rd_en   = slot_valid;
        rd_addr = slot_valid ? slot_addr : centre;
        if (k == 4'd8) state_next = S_WAIT;
      end
      S_WAIT:  state_next = S_EMIT;
      S_EMIT: begin
        conv_en    = 1'b1;
        state_next = advance ? S_FETCH : S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      row       <= '0;
      col       <= '0;
      i         <= '0;
      prov      <= '0;
      matrix_l  <= '0;
      matrix2_l <= '0;
      base_l    <= '0;
      cap_en    <= 1'b0;
      cap_k     <= '0;
      cap_valid <= 1'b0;
      // NOTE: the window is nine discrete output registers, not a RAM, so
      // resetting them is cheap and gives clean outputs after reset.
      for (int s = 0; s < 9; s++) win[s] <= '0;
    end else begin
      cap_en    <= (state == S_FETCH);
      cap_k     <= k;
      cap_valid <= slot_valid;
      if (cap_en) win[cap_k] <= cap_valid ? rd_data : '0;

      k <= ((state == S_FETCH) && (k != 4'd8)) ? k + 4'd1 : 4'd0;

      if ((state == S_IDLE) && start) begin
        matrix_l  <= matrix;
        matrix2_l <= matrix2;
        base_l    <= base_addr;
        i         <= '0;
        row       <= '0;
        col       <= '0;
        prov      <= 2'b11;
      end else if (advance) begin
        i <= i + 10'd1;
        if (col == last_idx) begin
          col  <= '0;
          row  <= row + 5'd1;
          prov <= 2'b11;
        end else begin
          col  <= col + 5'd1;
          // prov follows the column the next window will sit in.
          prov <= (col + 5'd1 == last_idx) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  assign w1 = win[0];
  assign w2 = win[1];
  assign w3 = win[2];
  assign w4 = win[3];
  assign w5 = win[4];
  assign w6 = win[5];
  assign w7 = win[6];
  assign w8 = win[7];
  assign w9 = win[8];

endmodule
